// File: rtl/count_ones_ctrl.sv
// Purpose: controller that sequences a count-ones datapath (load, clear one set bit per cycle, count) with a watchdog.
// Latency: a start accepted in cycle T with popcount k gives done in cycle T+k+2; a stuck datapath reaches ERROR after INPUT_WIDTH clears.
// Backpressure: none; go is a level request taken only when armed (go seen low since the last start) and not busy.
module count_ones_ctrl #(
  parameter int INPUT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic n_eq_0,
  output logic n_en,
  output logic n_sel,
  output logic count_en,
  output logic count_sel,
  output logic out_en,
  output logic done,
  output logic busy,
  output logic err
);

  localparam int ITER_WIDTH = $clog2(INPUT_WIDTH + 1);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX = ITER_WIDTH'(INPUT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  armed, armed_nxt;
  logic [ITER_WIDTH-1:0] iter, iter_nxt;
  logic                  accept;

  // A start needs a fresh rising request: holding go high never restarts.
  assign accept = (state != BUSY) && go && armed;

  // Next-state, arm tracking, iteration count and all control outputs.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    armed_nxt = go ? armed : 1'b1;
    n_en      = 1'b0;
    n_sel     = 1'b0;
    count_en  = 1'b0;
    count_sel = 1'b0;
    out_en    = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;

    // Start cycle: load operand and clear count; status outputs of the
    // current state remain visible for this one cycle.
    if (accept) begin
      n_en      = 1'b1;
      n_sel     = 1'b1;
      count_en  = 1'b1;
      count_sel = 1'b1;
      state_nxt = BUSY;
      iter_nxt  = '0;
      armed_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
      end
      BUSY: begin
        busy = 1'b1;
        if (n_eq_0) begin
          state_nxt = DONE;
        end else if (iter < ITER_MAX) begin
          // Clear lowest set bit; datapath bumps its count alongside.
          n_en     = 1'b1;
          n_sel    = 1'b0;
          iter_nxt = iter + ITER_WIDTH'(1);
        end else begin
          // More clears than operand bits: datapath is broken.
          state_nxt = ERROR;
        end
      end
      DONE: begin
        done   = 1'b1;
        out_en = 1'b1;
      end
      ERROR: begin
        err = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are held quiet for the whole reset cycle.
    if (rst) begin
      n_en      = 1'b0;
      n_sel     = 1'b0;
      count_en  = 1'b0;
      count_sel = 1'b0;
      out_en    = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
    end
  end

  // State, arm flag and iteration counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      armed <= armed_nxt;
      iter  <= iter_nxt;
    end
  end

endmodule

// File: tb/tb_count_ones_ctrl.sv
// Bench for count_ones_ctrl with a behavioural count-ones datapath around it.
// Operations are pushed to a scoreboard when started and checked when done rises.
// Table-driven operand runs plus hand sequences for hold-go, watchdog and mid-op reset.
module tb_count_ones_ctrl;

  logic clk = 1'b0;
  logic rst, go, n_eq_0;
  logic n_en, n_sel, count_en, count_sel, out_en, done, busy, err;

  always #5 clk = ~clk;

  count_ones_ctrl #(.INPUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .go(go), .n_eq_0(n_eq_0),
    .n_en(n_en), .n_sel(n_sel), .count_en(count_en), .count_sel(count_sel),
    .out_en(out_en), .done(done), .busy(busy), .err(err)
  );

  // Datapath model: operand register, clear-lowest-bit, count register.
  logic [31:0] din;
  logic        stub;
  logic [31:0] dp_n = '0;
  logic [7:0]  dp_count = '0;
  logic [7:0]  dp_out;

  always @(posedge clk) begin
    if (n_en) dp_n <= n_sel ? din : (dp_n & (dp_n - 32'd1));
    if (count_en && count_sel) dp_count <= '0;
    else if (n_en && !n_sel)   dp_count <= dp_count + 8'd1;
  end

  assign n_eq_0 = stub ? 1'b0 : (dp_n == '0);
  assign dp_out = out_en ? dp_count : 8'd0;

  typedef struct {
    int k;
    int done_cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] op;
    int          k;
  } vec_t;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_en_total = 0;
  int busy_total = 0;
  int done_rises = 0;
  logic prev_done = 1'b0;
  logic done_rise;
  logic [7:0] s_outs;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Sample one cycle at the falling edge, score done events, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_outs    = {n_en, n_sel, count_en, count_sel, out_en, done, busy, err};
    done_rise = done && !prev_done;
    prev_done = done;
    if (n_en) n_en_total++;
    if (busy) busy_total++;
    if (done_rise) begin
      done_rises++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no operation pending", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("result", int'(dp_out), e.k);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_rise) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
  endtask

  // Start an operation (go must have been low last cycle) and run it to done.
  task automatic run_op(input logic [31:0] op, input int k, input int from_done);
    int n0, b0;
    din = op;
    go  = 1'b1;
    sb.push_back('{k: k, done_cyc: cyc + k + 2});
    n0 = n_en_total;
    b0 = busy_total;
    tick();
    chk("accept_outs", int'(s_outs), from_done != 0 ? 8'hFC : 8'hF0);
    go = 1'b0;
    wait_done(60);
    chk("n_en_pulses", n_en_total - n0, k + 1);
    chk("busy_cycles", busy_total - b0, k + 1);
    tick();
  endtask

  initial begin
    int t, n0, r0, got;

    vecs[0] = '{op: 32'h0000_00B1, k: 4};
    vecs[1] = '{op: 32'h0000_0000, k: 0};
    vecs[2] = '{op: 32'hFFFF_FFFF, k: 32};
    vecs[3] = '{op: 32'h8000_0000, k: 1};
    vecs[4] = '{op: 32'hF0F0_F0F0, k: 16};
    vecs[5] = '{op: 32'h0000_0001, k: 1};

    rst = 1'b1; go = 1'b1; din = '0; stub = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_outs", int'(s_outs), 0);
    end
    rst = 1'b0; go = 1'b0;
    tick();
    chk("idle_outs", int'(s_outs), 0);

    // Table of operands, each run start-to-done.
    for (int i = 0; i < 6; i++) run_op(vecs[i].op, vecs[i].k, i);

    // Hold go high across completion: exactly one operation, DONE persists.
    din = 32'h0000_0007; go = 1'b1;
    sb.push_back('{k: 3, done_cyc: cyc + 5});
    r0 = done_rises;
    tick();
    chk("hold_accept_outs", int'(s_outs), 8'hFC);
    for (int i = 0; i < 15; i++) tick();
    chk("hold_one_op", done_rises - r0, 1);
    chk("hold_sb_empty", sb.size(), 0);
    chk("hold_done_persists", int'(s_outs), 8'h0C);
    go = 1'b0;
    tick();
    din = 32'h0000_0001; go = 1'b1;
    sb.push_back('{k: 1, done_cyc: cyc + 3});
    tick();
    chk("restart_accept_outs", int'(s_outs), 8'hFC);
    go = 1'b0;
    tick();
    chk("restart_done_low", int'(s_outs), 8'h82);
    wait_done(10);
    tick();

    // Watchdog: datapath never reports zero.
    stub = 1'b1; din = 32'hFFFF_FFFF; go = 1'b1;
    t = cyc; n0 = n_en_total;
    tick();
    go = 1'b0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (s_outs[0]) begin
        got = 1;
        break;
      end
    end
    chk("err_seen", got, 1);
    chk("err_cycle", cyc - 1, t + 34);
    chk("err_clears", n_en_total - n0, 33);
    chk("err_outs", int'(s_outs), 8'h01);
    tick(); tick();
    chk("err_holds", int'(s_outs), 8'h01);
    stub = 1'b0; din = 32'h0000_0003; go = 1'b1;
    sb.push_back('{k: 2, done_cyc: cyc + 4});
    tick();
    chk("err_accept_outs", int'(s_outs), 8'hF1);
    go = 1'b0;
    tick();
    chk("err_cleared_busy", int'(s_outs), 8'h82);
    wait_done(10);
    tick();

    // Reset in the middle of an operation; go held high must not restart.
    din = 32'hF0F0_F0F0; go = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("midop_busy", int'(s_outs[1]), 1);
    rst = 1'b1;
    tick();
    chk("rst_outs", int'(s_outs), 0);
    rst = 1'b0;
    n0 = n_en_total;
    tick();
    chk("post_rst_outs", int'(s_outs), 0);
    tick(); tick(); tick();
    chk("post_rst_no_start", n_en_total - n0, 0);
    go = 1'b0;
    tick();
    chk("post_rst_idle", int'(s_outs), 0);
    din = 32'h0000_0000; go = 1'b1;
    sb.push_back('{k: 0, done_cyc: cyc + 2});
    tick();
    chk("post_rst_accept", int'(s_outs), 8'hF0);
    go = 1'b0;
    wait_done(10);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_ones_ctrl.md
Name: count_ones_ctrl

Overview:
- FSM controller that sequences the count-ones datapath. The datapath loads an operand, clears one set bit per cycle, and counts the clears.
- Accepts a start request on `go`. Drives the datapath enables/selects from the datapath's `n_eq_0` status. Signals completion with `done`/`out_en`.
- Includes a watchdog that flags a datapath that fails to reach zero within INPUT_WIDTH clears.
- Sits between the top-level handshake and the datapath; one instance per datapath.

Parameters:
- INPUT_WIDTH, 32, datapath operand width. Bounds the legal iteration count.
- ITER_WIDTH (localparam), $clog2(INPUT_WIDTH+1), iteration counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start request, level. Accepted only when armed (see Behaviour).
- n_eq_0  input  1  datapath status: operand register is zero.
- n_en  output  1  datapath operand register update enable.
- n_sel  output  1  1 = load external input, 0 = clear lowest set bit.
- count_en  output  1  datapath count control enable.
- count_sel  output  1  with count_en, clears the datapath count.
- out_en  output  1  datapath drives count on its output.
- done  output  1  result valid.
- busy  output  1  operation in progress.
- err  output  1  watchdog fault: datapath did not reach zero.

Behaviour:
- States: IDLE, BUSY, DONE, ERROR. All control outputs are combinational from state, go, armed, n_eq_0 and iter.
- Reset: clk is the only clock, and rst is sampled on its rising edge, synchronous and active-high. While rst=1, all outputs are forced 0. Reset sets:
  - state = IDLE
  - armed = 0
  - iter = 0
- Arm flag: set on any cycle with go=0; cleared on the cycle a start is accepted. A start is accepted iff state ∈ {IDLE, DONE, ERROR}, go=1 and armed=1. Holding go high never restarts a second operation.
- Start cycle (accept): n_en=1, n_sel=1, count_en=1, count_sel=1. This loads the operand and clears the count. Next state is BUSY, iter <= 0.
- IDLE, no accept: all outputs 0.
- BUSY, n_eq_0=0 and iter<INPUT_WIDTH:
  - n_en=1, n_sel=0 (datapath clears a bit and increments count).
  - iter <= iter+1; stay in BUSY.
- BUSY, n_eq_0=1: no enables; next state DONE.
- BUSY, n_eq_0=0 and iter==INPUT_WIDTH: no enables; next state ERROR.
- BUSY: busy=1; done=0; out_en=0; go is ignored, though armed still tracks go=0.
- DONE: done=1, out_en=1, busy=0.
  - Holds until an accepted start.
  - On the accept cycle, the start controls are driven and done/out_en stay 1 for that cycle. They fall on the next cycle (BUSY).
- ERROR: err=1, done=0, out_en=0. Exits only via accepted start (err drops next cycle) or rst.
- Latency: start accepted in cycle T with operand popcount k. Then:
  - BUSY occupies cycles T+1 … T+k+1.
  - done=1 first in cycle T+k+2.
  - Operand 0 gives done at T+2.
  - Result presented on the datapath output = k.
- Reset mid-operation returns to IDLE immediately. Since armed resets to 0, go must be seen low before the next start.
- iter saturates; it never wraps.

Test Plan:
- Reset, then go=0 for 1 cycle, then go=1 for 1 cycle with in=32'h0000_00B1. Required: BUSY for 5 cycles, done=1 at T+6, datapath output=4, n_en high for 5 cycles (1 load + 4 clears).
- in=0, start at T. Required: done at T+2, output=0, exactly one n_en pulse (load).
- in=32'hFFFF_FFFF. Required: done at T+34, output=32, busy high for 33 cycles.
- Hold go=1 continuously across completion. Required: exactly one operation, DONE persists. Drop go for 1 cycle then raise it: restart, done low the cycle after accept.
- Stub n_eq_0 tied 0, start. Required: 32 clear cycles (iter 0..31), then ERROR with err=1 and no enables. A subsequent accepted start clears err and enters BUSY.
- Assert rst for 1 cycle mid-BUSY (in=32'hF0F0_F0F0, 3 cycles after start). Required: all outputs 0 the next cycle, state IDLE, go=1 ignored until go=0 is observed.
